// File: rtl/mux_n_pipe.sv
// N-to-1 channel mux with a registered, fully-handshaked output stage.
// A main/skid register pair keeps in_ready independent of out_ready.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] main_data, skid_data, cap_data;
  logic             main_err, skid_err, cap_err;
  logic             main_valid, skid_valid;
  logic             accept, main_free;

  // Out-of-range select captures zeros and flags the beat.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_free = ~main_valid | out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // Skid always drains first; in_ready is low then, so no beat competes.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= cap_data;
        main_err   <= cap_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= cap_data;
      skid_err   <= cap_err;
    end
  end

  assign out_data    = main_data;
  assign out_sel_err = main_err;
  assign out_valid   = main_valid;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and scoreboard checks for mux_n_pipe (N=4 main instance, N=3 side instance).
module tb_mux_n_pipe;

  logic         clk = 1'b0;
  logic         clrn;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid, flush, out_ready;
  logic         in_ready, out_sel_err, out_valid;
  logic [31:0]  out_data;

  logic         in_ready3, out_sel_err3, out_valid3;
  logic [31:0]  out_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .clk(clk), .clrn(clrn), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_pipe #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
    .clk(clk), .clrn(clrn), .in_data(in_data[95:0]), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready3), .flush(flush),
    .out_data(out_data3), .out_sel_err(out_sel_err3),
    .out_valid(out_valid3), .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Place value v on channel ch; other channels carry filler.
  task automatic offer(input logic [31:0] v, input logic [1:0] ch);
    in_data = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    in_data[ch*32 +: 32] = v;
    sel      = ch;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; sel = '0;
    #3;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0)  begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", out_sel_err); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    step(); step();
    clrn = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL post_reset_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    offer(32'hDEAD_BEEF, 2'd2);
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_data got %h exp deadbeef", out_data); end
    checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", out_sel_err); end
    step();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1;
    offer(32'h1234_5678, 2'd3);
    step();
    in_valid = 1'b0;
    checks++; if (out_data3 !== 32'h0)  begin errors++; $display("FAIL selerr_data got %h exp 0", out_data3); end
    checks++; if (out_sel_err3 !== 1'b1) begin errors++; $display("FAIL selerr_flag got %b exp 1", out_sel_err3); end
    checks++; if (out_valid3 !== 1'b1)  begin errors++; $display("FAIL selerr_valid got %b exp 1", out_valid3); end
    checks++; if (out_data !== 32'h1234_5678) begin errors++; $display("FAIL sel3_n4_data got %h exp 12345678", out_data); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL sel3_n4_err got %b exp 0", out_sel_err); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(32'hAAAA_0001, 2'd0); step();
    offer(32'hBBBB_0002, 2'd1); step();
    checks++; if (out_data !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_a_out got %h exp aaaa0001", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_skid_full got %b exp 0", in_ready); end
    offer(32'hCCCC_0003, 2'd3); step();
    checks++; if (out_data !== 32'hAAAA_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_held got %h/%b exp aaaa0001/1", out_data, out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_c_blocked got %b exp 0", in_ready); end
    out_ready = 1'b1; step();
    checks++; if (out_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_b_out got %h exp bbbb0002", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_skid_drained got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hCCCC_0003 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_c_out got %h/%b exp cccc0003/1", out_data, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(32'h0F0F_0001, 2'd1); step();
    offer(32'h0F0F_0002, 2'd2); step();
    offer(32'hDDDD_DDDD, 2'd0); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    out_ready = 1'b1; step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_absent got %b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(32'h5555_0001, 2'd0); step();
    offer(32'h5555_0002, 2'd3); step();
    in_valid = 1'b0;
    #3 clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL arst_data got %h exp 0", out_data); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_ready got %b exp 1", in_ready); end
    step();
    #2 clrn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_ghost got %b exp 0", out_valid); end
    end
  endtask

  task automatic test_throughput();
    logic [31:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v = 32'h7100_0000 + 32'(i);
      offer(v, 2'(i));
      step();
      checks++; if (out_data !== v || out_valid !== 1'b1) begin errors++; $display("FAIL tput_beat%0d got %h/%b exp %h/1", i, out_data, out_valid, v); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tput_ready%0d got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] expd;
    logic        acc, cons;
    flush = 1'b1; in_valid = 1'b0; step(); flush = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      sel       = 2'($urandom_range(0, 3));
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, out_data, q[0]); end
      end
      acc  = in_valid && (q.size() < 2);
      cons = out_ready && (q.size() > 0);
      expd = in_data[sel*32 +: 32];
      step();
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(expd);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_err();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_throughput();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
